usb_tx_packetizer: RTL and testbench
====================================

// Module: usb_tx_packetizer
// PURPOSE
// - USB 2.0 full-speed transmit packet framer, directly upstream of the bit-level PHY transmitter.
// - Turns a start request (PID + optional payload byte stream) into the byte sequence PID, payload, CRC16.
// - Delivers those bytes to the PHY transmitter over its valid/one-cycle-ready byte handshake.
// - Handshake PIDs (ACK/NAK/STALL/NYET) go out as a single PID byte. Data PIDs (pid_i[1:0]==2'b11) get a CRC16 appended.
// PARAMETERS
// - none. Clock-rate independent; the PHY paces all consumption through tx_ready_i.
// PORTS
// clk_i          in   1  clock, 12MHz*BIT_SAMPLES of the PHY
// rstn_i         in   1  reset, asynchronous, active-low
// start_i        in   1  one-cycle request to send a packet; honoured only while busy_o==0
// pid_i          in   4  PID code, sampled with start_i
// zlp_i          in   1  data PID with zero-length payload, sampled with start_i
// data_valid_i   in   1  payload byte available
// data_i         in   8  payload byte
// data_last_i    in   1  qualifies data_i as the final payload byte
// data_ready_o   out  1  payload byte consumed this cycle (valid & ready)
// busy_o         out  1  packet in progress (state != IDLE)
// done_o         out  1  one-cycle pulse: last byte of packet handed to the PHY
// underrun_o     out  1  one-cycle pulse: payload not available when needed, packet aborted
// tx_valid_o     out  1  to PHY: byte request, held until tx_ready_i
// tx_data_o      out  8  to PHY: byte, stable while tx_valid_o==1
// tx_ready_i     in   1  from PHY: one-cycle pulse, current byte consumed
// BEHAVIOUR
// Reset:
// - All outputs are 0; state=IDLE; pay_full=0; crc=16'hFFFF.
// - Reset mid-packet drops tx_valid_o at once. The PHY then closes the packet with a bad CRC, which is acceptable.
// States: IDLE, PID, DATA, CRC_LO, CRC_HI.
// tx_data_o by state:
// - PID    : {~pid_q, pid_q}
// - DATA   : pay_q
// - CRC_LO : ~crc[7:0]
// - CRC_HI : ~crc[15:8]
// tx_valid_o by state:
// - 1 in PID, CRC_LO, CRC_HI.
// - pay_full in DATA.
// - 0 in IDLE.
// - Registered: goes high the cycle after start_i, low the cycle after the final tx_ready_i.
// Transitions:
// - IDLE: start_i -> PID. Latch pid_q, zlp_q; crc<=FFFF.
// - PID, tx_ready_i:
//   - handshake PID -> IDLE, done_o=1.
//   - zlp_q -> CRC_LO.
//   - otherwise, pay_full -> DATA.
//   - otherwise (pay_full==0) -> IDLE, underrun_o=1.
// - DATA, tx_ready_i:
//   - pay_last -> CRC_LO.
//   - next byte loaded the same cycle -> stay in DATA.
//   - otherwise -> IDLE, underrun_o=1.
// - CRC_LO, tx_ready_i -> CRC_HI.
// - CRC_HI, tx_ready_i -> IDLE, done_o=1.
// Payload buffer (1 byte: pay_q, pay_full, pay_last):
// - data_ready_o = (state==PID|DATA) & data pid & !zlp_q & !last_taken & (!pay_full | (state==DATA & tx_ready_i)).
// - The first byte may prefetch during PID. A refill coincides with the tx_ready_i that empties the buffer.
// - Upstream must hold data_valid_i high at those cycles. A byte loaded at a tx_ready_i cycle is presented from the next cycle.
// - last_taken is set when a byte with data_last_i is loaded. No further bytes are taken until IDLE.
// - data_valid_i / data_last_i are ignored for handshake or ZLP packets.
// CRC16:
// - Polynomial 0x8005, reflected form 0xA001, LSB-first.
// - Updated one byte per cycle as each byte is loaded into pay_q.
// - Sent inverted, low byte first. A ZLP sends 00 00.
// Other rules:
// - start_i while busy_o==1 is ignored; pid_q/zlp_q are unchanged.
// - tx_ready_i in IDLE is ignored.
// - Maximum payload length is not enforced here.
// TESTING
// - Handshake: start_i with pid=4'b0010 -> exactly one byte 0xD2, then done_o; tx_valid_o low the cycle after tx_ready_i.
// - ZLP: pid=4'b0011, zlp=1 -> bytes C3 00 00; data_ready_o never asserted.
// - DATA1 payload "123456789" (31..39, last on 39) -> 4B 31..39 C8 B4, done_o once.
// - Underrun: DATA0 with data_valid_i low after the 2nd byte -> underrun_o pulse, tx_valid_o drops, state IDLE, no done_o.
// - start_i pulsed mid-packet -> ignored, byte sequence unchanged. Back-to-back start_i the cycle after done_o -> accepted.
// - rstn_i asserted during DATA -> outputs 0 immediately; the next packet after release is correct (CRC restarts at FFFF).

Source files
------------

// File: rtl/usb_tx_packetizer.sv
// USB full-speed transmit framer: emits PID, optional payload and inverted CRC16
// to the bit-level PHY transmitter over a valid / one-cycle-ready byte handshake.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for start_i
// S_PID    | presenting {~pid, pid}; first payload byte may prefetch
// S_DATA   | presenting buffered payload byte; refill on tx_ready_i
// S_CRC_LO | presenting ~crc[7:0]
// S_CRC_HI | presenting ~crc[15:8]
module usb_tx_packetizer (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  input  logic [3:0] pid_i,
  input  logic       zlp_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i
);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;

  state_t      state;
  logic [3:0]  pid_q;
  logic        zlp_q;
  logic [7:0]  pay_q;
  logic        pay_full;
  logic        pay_last;
  logic        last_taken;
  logic [15:0] crc;
  logic        is_data;
  logic        take;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign is_data = (pid_q[1:0] == 2'b11);

  // A refill is allowed in the same cycle the PHY empties the buffer.
  assign take = data_valid_i & ((state == S_PID) | (state == S_DATA)) & is_data & ~zlp_q
              & ~last_taken & (~pay_full | ((state == S_DATA) & tx_ready_i));

  assign data_ready_o = take;
  assign busy_o       = (state != S_IDLE);

  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    case (state)
      S_PID: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {~pid_q, pid_q};
      end
      S_DATA: begin
        tx_valid_o = pay_full;
        tx_data_o  = pay_q;
      end
      S_CRC_LO: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ~crc[7:0];
      end
      S_CRC_HI: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ~crc[15:8];
      end
      default: begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      pid_q      <= 4'h0;
      zlp_q      <= 1'b0;
      pay_q      <= 8'h00;
      pay_full   <= 1'b0;
      pay_last   <= 1'b0;
      last_taken <= 1'b0;
      crc        <= 16'hFFFF;
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
      if (take) begin
        pay_q      <= data_i;
        pay_full   <= 1'b1;
        pay_last   <= data_last_i;
        last_taken <= data_last_i;
        crc        <= crc16_byte(crc, data_i);
      end
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state      <= S_PID;
            pid_q      <= pid_i;
            zlp_q      <= zlp_i;
            crc        <= 16'hFFFF;
            pay_full   <= 1'b0;
            pay_last   <= 1'b0;
            last_taken <= 1'b0;
          end
        end
        S_PID: begin
          if (tx_ready_i) begin
            if (!is_data) begin
              state  <= S_IDLE;
              done_o <= 1'b1;
            end else if (zlp_q) begin
              state <= S_CRC_LO;
            end else if (pay_full) begin
              state <= S_DATA;
            end else begin
              state      <= S_IDLE;
              underrun_o <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tx_ready_i) begin
            if (pay_last) begin
              state    <= S_CRC_LO;
              pay_full <= 1'b0;
            end else if (!take) begin
              state      <= S_IDLE;
              pay_full   <= 1'b0;
              underrun_o <= 1'b1;
            end
          end
        end
        S_CRC_LO: begin
          if (tx_ready_i) state <= S_CRC_HI;
        end
        S_CRC_HI: begin
          if (tx_ready_i) begin
            state  <= S_IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Bench for usb_tx_packetizer: a PHY model pops expected bytes from a scoreboard
// queue on every tx_ready_i, while an upstream model streams payload bytes.
module tb_usb_tx_packetizer;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       start_i;
  logic [3:0] pid_i;
  logic       zlp_i;
  logic       data_valid_i;
  logic [7:0] data_i;
  logic       data_last_i;
  logic       data_ready_o;
  logic       busy_o;
  logic       done_o;
  logic       underrun_o;
  logic       tx_valid_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_mem[0:15];

  usb_tx_packetizer dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .pid_i(pid_i), .zlp_i(zlp_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_last_i(data_last_i),
    .data_ready_o(data_ready_o), .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Bit-serial reference CRC (LSB first, reflected 0x8005).
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  task automatic run_pkt(input logic [3:0] pid, input bit zlp, input int npay, input int stop_after,
                         input int gap, input bit mid_start, input int abort_cyc,
                         output int dones, output int unders, output int takes);
    int ptr;
    bit took;
    int vcnt;
    bit fin;
    logic [7:0] e;
    ptr = 0; took = 0; vcnt = 0; fin = 0;
    dones = 0; unders = 0; takes = 0;
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse_width: done_o=%b required 0", done_o);
    end
    pid_i = pid; zlp_i = zlp; start_i = 1'b1; tx_ready_i = 1'b0;
    if (npay == 0) begin
      data_valid_i = 1'b1; data_i = 8'hAA; data_last_i = 1'b1;
    end else begin
      data_valid_i = (stop_after > 0); data_i = pay_mem[0]; data_last_i = (npay == 1);
    end
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0; tx_ready_i = 1'b0;
      if (took) begin
        ptr++;
        if (ptr < npay) data_i = pay_mem[ptr];
        data_last_i  = (ptr == npay - 1);
        data_valid_i = (ptr < npay) && (ptr < stop_after);
      end
      took = 0;
      if (done_o) dones++;
      if (underrun_o) unders++;
      if (cyc == 0) begin
        n_checks++;
        if (busy_o !== 1'b1 || tx_valid_o !== 1'b1) begin
          n_fail++; $display("FAIL start_latency: busy=%b valid=%b required 1 1", busy_o, tx_valid_o);
        end
      end
      if (cyc == abort_cyc) begin
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({tx_valid_o, busy_o, data_ready_o, done_o, underrun_o, tx_data_o} !== 13'h0) begin
          n_fail++;
          $display("FAIL reset_mid_outputs: valid=%b busy=%b rdy=%b done=%b und=%b data=%h required all 0",
                   tx_valid_o, busy_o, data_ready_o, done_o, underrun_o, tx_data_o);
        end
        fin = 1;
      end else if (!busy_o) begin
        n_checks++;
        if (tx_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL valid_drop: tx_valid_o=%b required 0", tx_valid_o);
        end
        fin = 1;
      end else begin
        if (mid_start && cyc == 3) begin
          start_i = 1'b1; pid_i = 4'b0010; zlp_i = 1'b1;
        end
        if (tx_valid_o) begin
          vcnt++;
          if (vcnt >= gap) begin
            vcnt = 0;
            tx_ready_i = 1'b1;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL extra_byte: got %h required no byte", tx_data_o);
            end else begin
              e = exp_q.pop_front();
              if (tx_data_o !== e) begin
                n_fail++; $display("FAIL tx_byte: got %h required %h", tx_data_o, e);
              end
            end
          end
        end
        #1;
        took = data_ready_o;
        if (took) takes++;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: packet pid=%b still busy after 400 cycles", pid);
    end
    start_i = 1'b0; tx_ready_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0;
  endtask

  task automatic check_pkt(input string name, input int d, input int u, input int t,
                           input int ed, input int eu, input int et);
    n_checks++;
    if (d !== ed || u !== eu || t !== et || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: done=%0d und=%0d takes=%0d left=%0d required %0d %0d %0d 0",
               name, d, u, t, exp_q.size(), ed, eu, et);
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; start_i = 0; pid_i = 0; zlp_i = 0; data_valid_i = 0;
    data_i = 0; data_last_i = 0; tx_ready_i = 0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({tx_valid_o, busy_o, data_ready_o, done_o, underrun_o, tx_data_o} !== 13'h0) begin
      n_fail++; $display("FAIL reset_state: valid=%b busy=%b data=%h required 0", tx_valid_o, busy_o, tx_data_o);
    end
    rstn_i = 1'b1;
    @(negedge clk_i);
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    tx_ready_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready_ignored: busy=%b valid=%b required 0 0", busy_o, tx_valid_o);
    end
  endtask

  task automatic test_handshake();
    int d, u, t;
    exp_q.push_back(8'hD2);
    run_pkt(4'b0010, 1'b0, 0, 0, 3, 1'b0, -1, d, u, t);
    check_pkt("handshake", d, u, t, 1, 0, 0);
  endtask

  task automatic test_zlp();
    int d, u, t;
    exp_q.push_back(8'hC3); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    run_pkt(4'b0011, 1'b1, 0, 0, 2, 1'b0, -1, d, u, t);
    check_pkt("zlp", d, u, t, 1, 0, 0);
  endtask

  task automatic test_data1_check();
    int d, u, t;
    exp_q.push_back(8'h4B);
    for (int i = 0; i < 9; i++) begin
      pay_mem[i] = 8'h31 + 8'(i);
      exp_q.push_back(8'h31 + 8'(i));
    end
    exp_q.push_back(8'hC8); exp_q.push_back(8'hB4);
    run_pkt(4'b1011, 1'b0, 9, 9, 2, 1'b0, -1, d, u, t);
    check_pkt("data1_123456789", d, u, t, 1, 0, 9);
  endtask

  task automatic test_random_payload(input logic [3:0] pid, input int n, input bit mid_start);
    int d, u, t;
    logic [15:0] c;
    c = 16'hFFFF;
    exp_q.push_back({~pid, pid});
    for (int i = 0; i < n; i++) begin
      pay_mem[i] = 8'($urandom_range(0, 255));
      exp_q.push_back(pay_mem[i]);
      c = crc_model(c, pay_mem[i]);
    end
    exp_q.push_back(~c[7:0]); exp_q.push_back(~c[15:8]);
    run_pkt(pid, 1'b0, n, n, $urandom_range(2, 5), mid_start, -1, d, u, t);
    check_pkt("random_payload", d, u, t, 1, 0, n);
  endtask

  task automatic test_back_to_back();
    int d, u, t;
    exp_q.push_back(8'h5A);
    run_pkt(4'b1010, 1'b0, 0, 0, 2, 1'b0, -1, d, u, t);
    check_pkt("b2b_nak", d, u, t, 1, 0, 0);
    test_random_payload(4'b1011, 3, 1'b0);
  endtask

  task automatic test_underrun();
    int d, u, t;
    for (int i = 0; i < 5; i++) pay_mem[i] = 8'h10 + 8'(i);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    run_pkt(4'b0011, 1'b0, 5, 2, 3, 1'b0, -1, d, u, t);
    check_pkt("underrun", d, u, t, 0, 1, 2);
  endtask

  task automatic test_reset_mid();
    int d, u, t;
    for (int i = 0; i < 5; i++) pay_mem[i] = 8'h55 + 8'(i);
    exp_q.push_back(8'h4B);
    for (int i = 0; i < 5; i++) exp_q.push_back(pay_mem[i]);
    run_pkt(4'b1011, 1'b0, 5, 5, 2, 1'b0, 6, d, u, t);
    exp_q.delete();
    @(negedge clk_i);
    rstn_i = 1'b1;
    test_data1_check();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_zlp();
    test_data1_check();
    test_random_payload(4'b0011, 6, 1'b1);
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
